mode_arbiter: RTL
=================

MODE_ARBITER -- requirements
Module: mode_arbiter

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- tick_1hz  input  1  one-cycle pulse, once per second
- btn_mode  input  1  pulsed mode button
- btn_set  input  1  pulsed set button
- btn_up  input  1  pulsed up button
- btn_down  input  1  pulsed down button
- in_disp_state  input  4  bit i high when mode i sub-block is idle (not setting)
- alarm_match  input  1  one-cycle pulse, alarm time reached
- set_done  input  1  one-cycle pulse, any sub-block finished a set sequence
- current_mode  output  2  0 clock, 1 alarm, 2 stopwatch, 3 timer
- set_out  output  4  routed set pulse, one bit per mode
- up_out  output  4  routed up pulse, one bit per mode
- down_out  output  4  routed down pulse, one bit per mode
- alarm_ringing  output  1  ring FSM in RINGING
- snoozing  output  1  ring FSM in SNOOZE
- snooze_count  output  2  snoozes taken in the current alarm event

REQ-002 SHALL use reset as asynchronous and active-high, and clk as the clock. All state SHALL be on posedge clk.

Function
REQ-003 Mode FSM SHALL cycle CLOCK(0) -> ALARM(1) -> STOPWATCH(2) -> TIMER(3) -> CLOCK on an accepted btn_mode; current_mode SHALL update the next cycle.
REQ-004 btn_mode SHALL be accepted only if in_disp_state[current_mode]=1 and the ring FSM is not RINGING; otherwise it SHALL be dropped, not queued.
REQ-005 Button routing SHALL be registered, with 1-cycle latency: btn_x in cycle N gives x_out[current_mode(N)]=1 for exactly cycle N+1. All other bits SHALL be 0.
REQ-006 Priority within one cycle SHALL be: ring-FSM consumption > accepted btn_mode > forwarding. In a cycle with an accepted btn_mode, btn_set, btn_up and btn_down SHALL be dropped.
REQ-007 Ring FSM SHALL have states IDLE, RINGING and SNOOZE. alarm_match in IDLE -> RINGING; ring_sec (6-bit) SHALL clear to 0.
REQ-008 In RINGING, each tick_1hz SHALL increment ring_sec. The tick that makes ring_sec reach 60 SHALL move the FSM to IDLE (auto timeout).
REQ-009 In RINGING, the following SHALL each move the FSM to IDLE next cycle: btn_down (consumed, not forwarded) or set_done. btn_down takes precedence over a same-cycle tick timeout.
REQ-010 alarm_match while RINGING or SNOOZE SHALL be ignored.
REQ-011 btn_set SHALL be forwarded normally in RINGING.
REQ-012 On any entry to IDLE, snooze_count SHALL clear to 0.
REQ-013 alarm_ringing and snoozing SHALL be registered decodes of the ring state.

Reset
REQ-014 While reset is asserted, the block SHALL hold: current_mode=0, all *_out=0, ring FSM IDLE, ring_sec=0, snooze counter=0, snooze_count=0, alarm_ringing=0, snoozing=0.
REQ-015 Reset mid-RINGING or mid-SNOOZE SHALL abandon the event; no ring SHALL resume after release.

Configuration
REQ-016 With macro MODE_ARBITER_SNOOZE_EN defined, btn_up in RINGING with snooze_count<3 SHALL be consumed, increment snooze_count, and move to SNOOZE. The 9-bit snooze_sec SHALL load 300.
REQ-017 With MODE_ARBITER_SNOOZE_EN defined, btn_up in RINGING with snooze_count=3 SHALL be consumed with no effect.
REQ-018 With MODE_ARBITER_SNOOZE_EN defined, each tick_1hz in SNOOZE SHALL decrement snooze_sec. The tick reaching 0 SHALL return the FSM to RINGING with ring_sec=0.
REQ-019 With MODE_ARBITER_SNOOZE_EN defined, btn_down or set_done in SNOOZE SHALL move the FSM to IDLE, with btn_down consumed.
REQ-020 Without MODE_ARBITER_SNOOZE_EN, SNOOZE SHALL be unreachable. btn_up in RINGING SHALL be consumed with no effect, and snoozing and snooze_count SHALL be tied to 0.

Verification
REQ-021 Bench SHALL cover:
- in_disp_state=4'b1111; btn_mode x4 -> current_mode 1,2,3,0, each one cycle after its press.
- current_mode=2, btn_up -> up_out=4'b0100 for exactly one cycle, one cycle after the press.
- in_disp_state[0]=0, btn_mode -> current_mode stays 0. Same-cycle btn_mode+btn_set with in_disp_state=4'b1111 -> mode 1, set_out stays 0.
- alarm_match, then 60 tick_1hz -> alarm_ringing 1, then 0 after the 60th tick. Second alarm_match mid-ring -> no effect.
- RINGING, btn_down -> alarm_ringing 0 next cycle, down_out stays 0.
- SNOOZE_EN: RINGING, btn_up -> snoozing 1, snooze_count 1. After 300 ticks -> alarm_ringing 1. Repeat to snooze_count 3; 4th btn_up -> still ringing. Reset -> all outputs 0.

Source files
------------

// File: rtl/mode_arbiter.sv
// rtl/mode_arbiter.sv - display mode selector, button router and alarm ring/snooze controller
// Optional snooze support is compiled in with `define MODE_ARBITER_SNOOZE_EN.
module mode_arbiter (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1hz,
  input  logic       btn_mode,
  input  logic       btn_set,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic [3:0] in_disp_state,
  input  logic       alarm_match,
  input  logic       set_done,
  output logic [1:0] current_mode,
  output logic [3:0] set_out,
  output logic [3:0] up_out,
  output logic [3:0] down_out,
  output logic       alarm_ringing,
  output logic       snoozing,
  output logic [1:0] snooze_count
);

  typedef enum logic [1:0] {
    M_CLOCK     = 2'd0,
    M_ALARM     = 2'd1,
    M_STOPWATCH = 2'd2,
    M_TIMER     = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_RINGING = 2'd1,
    R_SNOOZE  = 2'd2
  } ring_t;

  localparam logic [5:0] RING_TIMEOUT = 6'd60;

  mode_t      mode_q, mode_d;
  ring_t      ring_q, ring_d;
  logic [5:0] ring_sec_q, ring_sec_d;

  logic       mode_accept;
  logic       up_consumed;
  logic       down_consumed;
  logic [3:0] mode_sel;
  logic [3:0] set_d, up_d, down_d;
  logic       ringing_d;

`ifdef MODE_ARBITER_SNOOZE_EN
  localparam logic [8:0] SNOOZE_SECONDS = 9'd300;
  localparam logic [1:0] SNOOZE_MAX     = 2'd3;

  logic [8:0] snooze_sec_q, snooze_sec_d;
  logic [1:0] snooze_cnt_q, snooze_cnt_d;
  logic       snoozing_d;
`endif

  // State and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q        <= M_CLOCK;
      ring_q        <= R_IDLE;
      ring_sec_q    <= '0;
      set_out       <= '0;
      up_out        <= '0;
      down_out      <= '0;
      alarm_ringing <= 1'b0;
`ifdef MODE_ARBITER_SNOOZE_EN
      snooze_sec_q  <= '0;
      snooze_cnt_q  <= '0;
      snoozing      <= 1'b0;
`endif
    end else begin
      mode_q        <= mode_d;
      ring_q        <= ring_d;
      ring_sec_q    <= ring_sec_d;
      set_out       <= set_d;
      up_out        <= up_d;
      down_out      <= down_d;
      alarm_ringing <= ringing_d;
`ifdef MODE_ARBITER_SNOOZE_EN
      snooze_sec_q  <= snooze_sec_d;
      snooze_cnt_q  <= snooze_cnt_d;
      snoozing      <= snoozing_d;
`endif
    end
  end

  // A mode change is refused while the alarm rings or the current sub-block is mid-set.
  always_comb begin
    mode_accept = btn_mode && in_disp_state[mode_q] && (ring_q != R_RINGING);
    mode_d      = mode_q;
    if (mode_accept) begin
      mode_d = mode_t'(mode_q + 2'd1);
    end
  end

  // Ring FSM next state
  always_comb begin
    ring_d     = ring_q;
    ring_sec_d = ring_sec_q;
`ifdef MODE_ARBITER_SNOOZE_EN
    snooze_sec_d = snooze_sec_q;
    snooze_cnt_d = snooze_cnt_q;
`endif
    case (ring_q)
      R_IDLE: begin
        if (alarm_match) begin
          ring_d     = R_RINGING;
          ring_sec_d = '0;
        end
      end
      R_RINGING: begin
        if (btn_down || set_done) begin
          ring_d = R_IDLE;
        end
`ifdef MODE_ARBITER_SNOOZE_EN
        else if (btn_up && (snooze_cnt_q != SNOOZE_MAX)) begin
          ring_d       = R_SNOOZE;
          snooze_cnt_d = snooze_cnt_q + 2'd1;
          snooze_sec_d = SNOOZE_SECONDS;
        end
`endif
        else if (tick_1hz) begin
          ring_sec_d = ring_sec_q + 6'd1;
          if (ring_sec_d == RING_TIMEOUT) begin
            ring_d = R_IDLE;
          end
        end
      end
`ifdef MODE_ARBITER_SNOOZE_EN
      R_SNOOZE: begin
        if (btn_down || set_done) begin
          ring_d = R_IDLE;
        end else if (tick_1hz) begin
          snooze_sec_d = snooze_sec_q - 9'd1;
          if (snooze_sec_d == 9'd0) begin
            ring_d     = R_RINGING;
            ring_sec_d = '0;
          end
        end
      end
`endif
      default: begin
        ring_d = R_IDLE;
      end
    endcase
    // Every return to idle ends the alarm event.
    if (ring_d == R_IDLE) begin
      ring_sec_d = '0;
`ifdef MODE_ARBITER_SNOOZE_EN
      snooze_cnt_d = '0;
      snooze_sec_d = '0;
`endif
    end
  end

  // Output decode: ring consumption beats an accepted mode press, which beats forwarding.
  always_comb begin
    mode_sel      = 4'b0001 << mode_q;
    up_consumed   = (ring_q == R_RINGING);
    down_consumed = (ring_q != R_IDLE);
    set_d         = (btn_set && !mode_accept) ? mode_sel : 4'b0000;
    up_d          = (btn_up && !mode_accept && !up_consumed) ? mode_sel : 4'b0000;
    down_d        = (btn_down && !mode_accept && !down_consumed) ? mode_sel : 4'b0000;
    ringing_d     = (ring_d == R_RINGING);
`ifdef MODE_ARBITER_SNOOZE_EN
    snoozing_d    = (ring_d == R_SNOOZE);
`endif
  end

  assign current_mode = mode_q;

`ifdef MODE_ARBITER_SNOOZE_EN
  assign snooze_count = snooze_cnt_q;
`else
  assign snoozing     = 1'b0;
  assign snooze_count = 2'd0;
`endif

endmodule
